// File: rtl/jump_scheduler.sv
// jump_scheduler
//   Buffers left/right key presses in a small FIFO. Each press is released as a
//   single jump_left/jump_right pulse, but only when the character is grounded
//   and the next block layer is ready. After every landing it requests a new
//   layer. It also aborts a jump that does not land in time, and it flushes the
//   queue when a jump fails or when the game is disabled.
//
// Parameters
//   DEPTH            press FIFO depth (1..4)
//   LAND_TIMEOUT_MS  one_ms_tick pulses allowed in the air before the jump is aborted
//
// Ports
//   clk             system clock
//   rst             asynchronous, active-low reset
//   enable          level: game is in its play state
//   key             00 none, 01 left, 10 right, 11 up (not used here)
//   one_ms_tick     single-cycle pulse, once every millisecond
//   landed          pulse: the character finished its jump
//   jump_fail       pulse: the character landed on an empty slot
//   map_ready       level: the next layer is available
//   jump_left       single-cycle jump command, to the left
//   jump_right      single-cycle jump command, to the right
//   layer_generate  single-cycle request for the next layer
//   queue_level     FIFO occupancy, 0..DEPTH
//   busy            high while the state is AIR or WAIT_MAP
//   press_dropped   pulse: a press was lost because the FIFO was full
//   timeout         pulse: a jump was aborted because it did not land in time
module jump_scheduler #(
  parameter int DEPTH           = 2,
  parameter int LAND_TIMEOUT_MS = 1500
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic [1:0] key,
  input  logic       one_ms_tick,
  input  logic       landed,
  input  logic       jump_fail,
  input  logic       map_ready,
  output logic       jump_left,
  output logic       jump_right,
  output logic       layer_generate,
  output logic [2:0] queue_level,
  output logic       busy,
  output logic       press_dropped,
  output logic       timeout
);

  localparam int              MS_W     = $clog2(LAND_TIMEOUT_MS + 1);
  localparam logic [MS_W-1:0] MS_LAST  = MS_W'(LAND_TIMEOUT_MS - 1);
  localparam logic [MS_W-1:0] MS_MAX   = MS_W'(LAND_TIMEOUT_MS);
  localparam logic [2:0]      LVL_FULL = 3'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_AIR, S_WAIT_MAP, S_HALT} state_t;

  state_t           state_q, state_d;
  logic [1:0]       key_q;
  logic [DEPTH-1:0] fifo_q, fifo_d, fifo_shift;
  logic [2:0]       level_d, lvl_after_pop;
  logic [MS_W-1:0]  ms_q, ms_d;
  logic             jl_d, jr_d, lg_d, drop_d, tmo_d, busy_d;
  logic             press, live, tmo_hit, tmo_evt, flush;
  logic             pop, push_try, push_ok;

  // A press is an edge onto left or right. Going directly from 01 to 10 also
  // counts as a new press.
  assign press   = ((key == 2'b01) || (key == 2'b10)) && (key != key_q);
  // The game is running and no failure is being reported in this cycle.
  assign live    = enable && !jump_fail;
  // This tick would be the LAND_TIMEOUT_MS-th one since the jump was issued.
  assign tmo_hit = one_ms_tick && (ms_q >= MS_LAST);

  // ---- next-state logic ----
  always_comb begin
    state_d = state_q;
    if (!enable) begin
      state_d = S_IDLE;
    end else if (jump_fail) begin
      state_d = S_HALT;
    end else begin
      case (state_q)
        S_IDLE:     if ((queue_level != 3'd0) && map_ready) state_d = S_AIR;
        S_AIR:      if (tmo_hit) state_d = S_IDLE;
                    else if (landed) state_d = S_WAIT_MAP;
        // While layer_generate is high, map_ready still describes the old layer.
        S_WAIT_MAP: if (!layer_generate && map_ready) state_d = S_IDLE;
        default:    state_d = S_HALT;
      endcase
    end
  end

  // ---- output / datapath next values ----
  always_comb begin
    pop      = live && (state_q == S_IDLE) && (queue_level != 3'd0) && map_ready;
    tmo_evt  = live && (state_q == S_AIR) && tmo_hit;
    flush    = !live || tmo_evt;
    push_try = live && press && (state_q != S_HALT) && !tmo_evt;
    // When the FIFO is full, a pop in the same cycle makes room for the push.
    push_ok  = push_try && ((queue_level < LVL_FULL) || pop);
    drop_d   = push_try && !push_ok;

    jl_d   = pop && !fifo_q[0];
    jr_d   = pop && fifo_q[0];
    lg_d   = live && (state_q == S_AIR) && !tmo_hit && landed;
    tmo_d  = tmo_evt;
    busy_d = (state_d == S_AIR) || (state_d == S_WAIT_MAP);

    // Entry 0 is the head. A pop shifts the FIFO down, and a push then
    // writes the first free slot that remains after the pop.
    fifo_shift    = pop ? (fifo_q >> 1) : fifo_q;
    lvl_after_pop = pop ? (queue_level - 3'd1) : queue_level;
    fifo_d        = fifo_shift;
    for (int i = 0; i < DEPTH; i++) begin
      if (push_ok && (lvl_after_pop == 3'(i))) fifo_d[i] = (key == 2'b10);
    end
    level_d = lvl_after_pop + {2'b00, push_ok};
    if (flush) begin
      fifo_d  = '0;
      level_d = 3'd0;
    end

    ms_d = ms_q;
    if (pop) begin
      ms_d = '0;
    end else if ((state_q == S_AIR) && one_ms_tick && (ms_q != MS_MAX)) begin
      ms_d = ms_q + MS_W'(1);
    end
  end

  // ---- state register ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // ---- control and output registers ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      key_q          <= 2'b00;
      queue_level    <= 3'd0;
      ms_q           <= '0;
      jump_left      <= 1'b0;
      jump_right     <= 1'b0;
      layer_generate <= 1'b0;
      busy           <= 1'b0;
      press_dropped  <= 1'b0;
      timeout        <= 1'b0;
    end else begin
      key_q          <= key;
      queue_level    <= level_d;
      ms_q           <= ms_d;
      jump_left      <= jl_d;
      jump_right     <= jr_d;
      layer_generate <= lg_d;
      busy           <= busy_d;
      press_dropped  <= drop_d;
      timeout        <= tmo_d;
    end
  end

  // ---- FIFO payload (validity is tracked by queue_level) ----
  always_ff @(posedge clk) begin
    fifo_q <= fifo_d;
  end

endmodule

// File: tb/tb_jump_scheduler.sv
module tb_jump_scheduler;

  localparam int DEPTH = 2;
  localparam int TMO   = 1500;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       enable = 1'b0;
  logic [1:0] key = 2'b00;
  logic       one_ms_tick = 1'b0;
  logic       landed = 1'b0;
  logic       jump_fail = 1'b0;
  logic       map_ready = 1'b0;
  logic       jump_left, jump_right, layer_generate, busy, press_dropped, timeout;
  logic [2:0] queue_level;

  jump_scheduler #(.DEPTH(DEPTH), .LAND_TIMEOUT_MS(TMO)) dut (
    .clk(clk), .rst(rst), .enable(enable), .key(key), .one_ms_tick(one_ms_tick),
    .landed(landed), .jump_fail(jump_fail), .map_ready(map_ready),
    .jump_left(jump_left), .jump_right(jump_right), .layer_generate(layer_generate),
    .queue_level(queue_level), .busy(busy), .press_dropped(press_dropped),
    .timeout(timeout)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check_val(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
  endtask

  // Reference model: the queue of pending presses plus the mode of the character.
  localparam int M_GROUND = 0, M_FLIGHT = 1, M_LAYER = 2, M_HALTED = 3;
  bit mq[$];
  int mode, ms_count, prev_key;
  bit layer_fresh;
  int e_jl, e_jr, e_lg, e_lvl, e_busy, e_drop, e_tmo;
  int jl_seen, jr_seen, tmo_seen;

  task automatic model_reset();
    mq.delete();
    mode = M_GROUND; ms_count = 0; prev_key = 0; layer_fresh = 0;
    e_jl = 0; e_jr = 0; e_lg = 0; e_lvl = 0; e_busy = 0; e_drop = 0; e_tmo = 0;
  endtask

  task automatic model_step(input int en, input int k, input int tk, input int ld,
                            input int jf, input int mr);
    int  old_mode;
    bit  newp, go, tmo, head;
    old_mode = mode; go = 0; tmo = 0;
    e_jl = 0; e_jr = 0; e_lg = 0; e_drop = 0; e_tmo = 0;
    newp = ((k == 1) || (k == 2)) && (k != prev_key);
    prev_key = k;
    if (en == 0) begin
      mq.delete(); mode = M_GROUND;
    end else if (jf != 0) begin
      mq.delete(); mode = M_HALTED;
    end else begin
      case (old_mode)
        M_GROUND: go = (mq.size() > 0) && (mr != 0);
        M_FLIGHT: begin
          if (tk != 0) ms_count++;
          if (ms_count >= TMO) tmo = 1;
          else if (ld != 0) begin e_lg = 1; mode = M_LAYER; layer_fresh = 1; end
        end
        M_LAYER: begin
          if (layer_fresh) layer_fresh = 0;
          else if (mr != 0) mode = M_GROUND;
        end
        default: ;
      endcase
      if (tmo) begin
        mq.delete(); mode = M_GROUND; e_tmo = 1;
      end else begin
        if (go) begin
          head = mq.pop_front();
          if (head) e_jr = 1; else e_jl = 1;
          mode = M_FLIGHT; ms_count = 0;
        end
        if (newp && (old_mode != M_HALTED)) begin
          if (mq.size() < DEPTH) mq.push_back(k == 2);
          else e_drop = 1;
        end
      end
    end
    e_lvl  = mq.size();
    e_busy = ((mode == M_FLIGHT) || (mode == M_LAYER)) ? 1 : 0;
  endtask

  task automatic cyc(input int en, input int k, input int tk, input int ld,
                     input int jf, input int mr);
    enable = en[0]; key = k[1:0]; one_ms_tick = tk[0];
    landed = ld[0]; jump_fail = jf[0]; map_ready = mr[0];
    @(posedge clk);
    model_step(en, k, tk, ld, jf, mr);
    #1;
    check_val("jump_left", jump_left, e_jl);
    check_val("jump_right", jump_right, e_jr);
    check_val("layer_generate", layer_generate, e_lg);
    check_val("queue_level", queue_level, e_lvl);
    check_val("busy", busy, e_busy);
    check_val("press_dropped", press_dropped, e_drop);
    check_val("timeout", timeout, e_tmo);
    jl_seen  += jump_left;
    jr_seen  += jump_right;
    tmo_seen += timeout;
  endtask

  task automatic reset_checks(input string tag);
    check_val({tag, "_jump_left"}, jump_left, 0);
    check_val({tag, "_jump_right"}, jump_right, 0);
    check_val({tag, "_layer_generate"}, layer_generate, 0);
    check_val({tag, "_queue_level"}, queue_level, 0);
    check_val({tag, "_busy"}, busy, 0);
    check_val({tag, "_press_dropped"}, press_dropped, 0);
    check_val({tag, "_timeout"}, timeout, 0);
  endtask

  initial begin
    int rk, rmr;
    model_reset();
    jl_seen = 0; jr_seen = 0; tmo_seen = 0;
    #12;
    reset_checks("por");
    @(posedge clk); #1 rst = 1'b1;

    // A held left key gives one jump, two cycles after the press.
    repeat (2) cyc(1, 0, 0, 0, 0, 1);
    jl_seen = 0;
    repeat (5) cyc(1, 1, 0, 0, 0, 1);
    repeat (3) cyc(1, 0, 0, 0, 0, 1);
    check_val("t1_jump_count", jl_seen, 1);
    check_val("t1_busy", busy, 1);

    // Presses made in the air fill the queue, and the third one is dropped.
    cyc(1, 2, 0, 0, 0, 1); cyc(1, 0, 0, 0, 0, 1);
    cyc(1, 1, 0, 0, 0, 1); cyc(1, 0, 0, 0, 0, 1);
    cyc(1, 2, 0, 0, 0, 1); cyc(1, 0, 0, 0, 0, 1);
    check_val("t2_level_full", queue_level, 2);
    jl_seen = 0; jr_seen = 0;
    cyc(1, 0, 0, 1, 0, 1);
    repeat (4) cyc(1, 0, 0, 0, 0, 1);
    check_val("t2_right_first", jr_seen, 1);
    cyc(1, 0, 0, 1, 0, 1);
    repeat (4) cyc(1, 0, 0, 0, 0, 1);
    check_val("t2_left_second", jl_seen, 1);
    cyc(1, 0, 0, 1, 0, 1);
    repeat (4) cyc(1, 0, 0, 0, 0, 1);

    // While map_ready is low, a queued press is held back.
    jl_seen = 0;
    cyc(1, 1, 0, 0, 0, 0); cyc(1, 0, 0, 0, 0, 0);
    repeat (6) cyc(1, 0, 0, 0, 0, 0);
    check_val("t3_held", jl_seen, 0);
    repeat (3) cyc(1, 0, 0, 0, 0, 1);
    check_val("t3_released", jl_seen, 1);

    // A jump that never lands is aborted on the TMO-th tick.
    cyc(1, 0, 0, 1, 0, 1);
    repeat (4) cyc(1, 0, 0, 0, 0, 1);
    cyc(1, 2, 0, 0, 0, 1); cyc(1, 0, 0, 0, 0, 1);
    cyc(1, 1, 0, 0, 0, 1); cyc(1, 0, 0, 0, 0, 1);
    tmo_seen = 0;
    repeat (TMO + 5) cyc(1, 0, 1, 0, 0, 0);
    check_val("t4_timeouts", tmo_seen, 1);
    check_val("t4_busy", busy, 0);
    check_val("t4_level", queue_level, 0);

    // A jump failure flushes the queue and halts until the game is disabled.
    cyc(1, 1, 0, 0, 0, 0); cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 2, 0, 0, 0, 0); cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 1, 0);
    check_val("t5_flushed", queue_level, 0);
    cyc(1, 1, 0, 0, 0, 1); cyc(1, 0, 0, 0, 0, 1);
    check_val("t5_ignored", queue_level, 0);
    cyc(0, 0, 0, 0, 0, 1);
    jl_seen = 0;
    cyc(1, 1, 0, 0, 0, 1);
    repeat (3) cyc(1, 0, 0, 0, 0, 1);
    check_val("t5_rejump", jl_seen, 1);

    // Asynchronous reset in the air, with two presses queued.
    cyc(1, 2, 0, 0, 0, 1); cyc(1, 0, 0, 0, 0, 1);
    cyc(1, 1, 0, 0, 0, 1); cyc(1, 0, 0, 0, 0, 1);
    check_val("t6_level", queue_level, 2);
    #3 rst = 1'b0;
    #1 reset_checks("arst");
    model_reset();
    key = 2'b00; landed = 1'b0; one_ms_tick = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    jl_seen = 0; jr_seen = 0;
    repeat (6) cyc(1, 0, 0, 0, 0, 1);
    check_val("t6_no_jump", jl_seen + jr_seen, 0);

    // Randomized traffic
    rk = 0; rmr = 1;
    for (int i = 0; i < 6000; i++) begin
      if ($urandom_range(0, 9) < 3) rk = $urandom_range(0, 3);
      if ($urandom_range(0, 4) == 0) rmr = $urandom_range(0, 1);
      cyc(($urandom_range(0, 149) != 0) ? 1 : 0, rk,
          ($urandom_range(0, 2) == 0) ? 1 : 0,
          ($urandom_range(0, 14) == 0) ? 1 : 0,
          ($urandom_range(0, 249) == 0) ? 1 : 0, rmr);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
